// File: rtl/tt_vector_checker_if.sv
// Bus between the truth-table checker and the function unit under test.
// master: the checker (drives vec and result flags); slave: the environment.
interface tt_vector_checker_if #(
  parameter int unsigned N_IN = 3
);
  logic            start;
  logic            f_in;
  logic [N_IN-1:0] vec;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   err_cnt;
  logic [N_IN-1:0] first_err_idx;
  logic            err_seen;

  modport master (
    input  start, f_in,
    output vec, busy, done, pass, err_cnt, first_err_idx, err_seen
  );

  modport slave (
    output start, f_in,
    input  vec, busy, done, pass, err_cnt, first_err_idx, err_seen
  );
endinterface

// File: rtl/tt_vector_checker.sv
// Clocked driver/checker for a combinational truth-table function unit.
// Walks every input vector, holds it SETTLE cycles, samples f_in and
// compares against EXP_TABLE; reports mismatch count, first failing index
// and pass/fail.
// Optional: define STOP_ON_ERR_EN to end the run on the first mismatch.
module tt_vector_checker #(
  parameter int unsigned         N_IN      = 3,
  parameter logic [2**N_IN-1:0]  EXP_TABLE = 8'hCE,
  parameter int unsigned         SETTLE    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  tt_vector_checker_if.master  bus
);

  localparam int unsigned N_VEC = 2**N_IN;
  localparam int unsigned CNT_W = $clog2(SETTLE + 1);
  localparam int unsigned ERR_W = N_IN + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [N_IN-1:0] vec_q, vec_nxt;
  logic            busy_q, busy_nxt;
  logic            done_q, done_nxt;
  logic            pass_q, pass_nxt;
  logic [ERR_W-1:0] err_q, err_nxt;
  logic [N_IN-1:0] first_q, first_nxt;
  logic            seen_q, seen_nxt;

  logic            mismatch_c;
  logic [ERR_W-1:0] err_sum_c;
  logic            stop_c;

  // State and registered outputs; async reset discards any partial run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      vec_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      first_q <= '0;
      seen_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      vec_q   <= vec_nxt;
      busy_q  <= busy_nxt;
      done_q  <= done_nxt;
      pass_q  <= pass_nxt;
      err_q   <= err_nxt;
      first_q <= first_nxt;
      seen_q  <= seen_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    vec_nxt   = vec_q;
    busy_nxt  = busy_q;
    done_nxt  = done_q;
    pass_nxt  = pass_q;
    err_nxt   = err_q;
    first_nxt = first_q;
    seen_nxt  = seen_q;

    mismatch_c = (state == SAMPLE) && (bus.f_in != EXP_TABLE[vec_q]);
    err_sum_c  = err_q + ERR_W'(mismatch_c);
    stop_c     = (vec_q == N_IN'(N_VEC - 1));
`ifdef STOP_ON_ERR_EN
    stop_c     = stop_c | mismatch_c;
`else
    stop_c     = stop_c | 1'b0;
`endif

    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          state_nxt = DRIVE;
          cnt_nxt   = '0;
          vec_nxt   = '0;
          busy_nxt  = 1'b1;
          done_nxt  = 1'b0;
          pass_nxt  = 1'b0;
          err_nxt   = '0;
          first_nxt = '0;
          seen_nxt  = 1'b0;
        end
      end
      DRIVE: begin
        cnt_nxt = cnt + CNT_W'(1);
        if (cnt == CNT_W'(SETTLE - 1)) begin
          state_nxt = SAMPLE;
        end
      end
      SAMPLE: begin
        if (mismatch_c) begin
          err_nxt = err_sum_c;
          if (!seen_q) begin
            first_nxt = vec_q;
            seen_nxt  = 1'b1;
          end
        end
        if (stop_c) begin
          state_nxt = DONE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          pass_nxt  = (err_sum_c == '0);
        end else begin
          state_nxt = DRIVE;
          vec_nxt   = vec_q + N_IN'(1);
          cnt_nxt   = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.vec           = vec_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.pass          = pass_q;
  assign bus.err_cnt       = err_q;
  assign bus.first_err_idx = first_q;
  assign bus.err_seen      = seen_q;

endmodule

// File: tb/tb_tt_vector_checker.sv
// Bench for tt_vector_checker: a run-level model predicts every output on
// every cycle, plus literal expectations for the directed scenarios.
module tb_tt_vector_checker;

  localparam int N_IN   = 3;
  localparam int N_VEC  = 8;
  localparam int SETTLE = 4;
  localparam int PER    = SETTLE + 1;
  localparam logic [7:0] EXP = 8'hCE;
`ifdef STOP_ON_ERR_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   mode = 0;   // 0 correct, 1 stuck0, 2 inverted, 3 stuck1
  int   nchk = 0;
  int   nerr = 0;

  tt_vector_checker_if #(.N_IN(N_IN)) bus ();

  tt_vector_checker #(.N_IN(N_IN), .EXP_TABLE(EXP), .SETTLE(SETTLE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic unit_f(input int m, input int i);
    logic [7:0] e;
    e = EXP;
    case (m)
      0: return e[i];
      1: return 1'b0;
      2: return ~e[i];
      default: return 1'b1;
    endcase
  endfunction

  // Function unit under test, behaviourally selected by mode.
  always_comb bus.f_in = unit_f(mode, int'(bus.vec));

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Run-level model state.
  bit m_run = 1'b0;
  bit m_done = 1'b0;
  int k = 0;
  int m_mode = 0;
  int run_vecs = N_VEC;

  // Per-cycle compare against the model, 1 time unit after each edge.
  always @(posedge clk) begin
    logic st, rs;
    int nsamp, e_err, e_first, e_vec;
    bit e_seen;
    st = bus.start;
    rs = rst;
    #1;
    if (rs) begin
      m_run = 1'b0; m_done = 1'b0; k = 0;
    end else if (!m_run && st) begin
      int fm;
      m_run = 1'b1; m_done = 1'b0; k = 1; m_mode = mode;
      fm = N_VEC;
      for (int i = N_VEC - 1; i >= 0; i--)
        if (unit_f(m_mode, i) != EXP[i]) fm = i;
      run_vecs = (STOP && fm < N_VEC) ? fm + 1 : N_VEC;
    end else if (m_run) begin
      k++;
      if (k == PER * run_vecs + 1) begin
        m_run = 1'b0; m_done = 1'b1;
      end
    end
    nsamp = m_run ? (k - 1) / PER : (m_done ? run_vecs : 0);
    e_vec = m_run ? (k - 1) / PER : (m_done ? run_vecs - 1 : 0);
    e_err = 0; e_first = 0; e_seen = 1'b0;
    for (int i = 0; i < nsamp; i++) begin
      if (unit_f(m_mode, i) != EXP[i]) begin
        if (!e_seen) e_first = i;
        e_seen = 1'b1;
        e_err++;
      end
    end
    chk("cyc_vec",   int'(bus.vec), e_vec);
    chk("cyc_busy",  int'(bus.busy), int'(m_run));
    chk("cyc_done",  int'(bus.done), int'(m_done));
    chk("cyc_pass",  int'(bus.pass), int'(m_done && e_err == 0));
    chk("cyc_err",   int'(bus.err_cnt), e_err);
    chk("cyc_first", int'(bus.first_err_idx), e_first);
    chk("cyc_seen",  int'(bus.err_seen), int'(e_seen));
  end

  // Start a run at a negedge and wait (bounded) for done; counts busy cycles.
  task automatic run(input int m, input bit hold, output int busy_cyc);
    bit got;
    mode = m;
    bus.start = 1'b1;
    busy_cyc = 0;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!hold) bus.start = 1'b0;
      if (bus.busy) busy_cyc++;
      if (bus.done) begin
        got = 1'b1;
        break;
      end
    end
    chk("done_timeout", int'(got), 1);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_vec"},   int'(bus.vec), 0);
    chk({nm, "_busy"},  int'(bus.busy), 0);
    chk({nm, "_done"},  int'(bus.done), 0);
    chk({nm, "_pass"},  int'(bus.pass), 0);
    chk({nm, "_err"},   int'(bus.err_cnt), 0);
    chk({nm, "_first"}, int'(bus.first_err_idx), 0);
    chk({nm, "_seen"},  int'(bus.err_seen), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc;
    bit hit;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Correct unit: full pass.
    run(0, 1'b0, bc);
    chk("ok_busy_cycles", bc, 40);
    chk("ok_pass", int'(bus.pass), 1);
    chk("ok_err", int'(bus.err_cnt), 0);
    chk("ok_seen", int'(bus.err_seen), 0);
    chk("ok_vec", int'(bus.vec), 7);

    // Stuck-at-0 unit.
    run(1, 1'b0, bc);
    chk("s0_pass", int'(bus.pass), 0);
    chk("s0_seen", int'(bus.err_seen), 1);
    chk("s0_first", int'(bus.first_err_idx), 1);
`ifdef STOP_ON_ERR_EN
    chk("s0_err", int'(bus.err_cnt), 1);
    chk("s0_vec", int'(bus.vec), 1);
    chk("s0_busy_cycles", bc, 10);
`else
    chk("s0_err", int'(bus.err_cnt), 5);
    chk("s0_busy_cycles", bc, 40);
`endif

    // Inverted unit.
    run(2, 1'b0, bc);
    chk("inv_pass", int'(bus.pass), 0);
    chk("inv_first", int'(bus.first_err_idx), 0);
`ifdef STOP_ON_ERR_EN
    chk("inv_err", int'(bus.err_cnt), 1);
`else
    chk("inv_err", int'(bus.err_cnt), 8);
`endif

    // Stuck-at-1 unit.
    run(3, 1'b0, bc);
    chk("s1_first", int'(bus.first_err_idx), 0);
`ifdef STOP_ON_ERR_EN
    chk("s1_err", int'(bus.err_cnt), 1);
`else
    chk("s1_err", int'(bus.err_cnt), 3);
`endif

    // Start held through the run: no restart until DONE, then immediate restart.
    run(1, 1'b1, bc);
`ifndef STOP_ON_ERR_EN
    chk("hold_busy_cycles", bc, 40);
`endif
    @(negedge clk);
    bus.start = 1'b0;
    chk("hold_restart_done", int'(bus.done), 0);
    chk("hold_restart_err", int'(bus.err_cnt), 0);
    chk("hold_restart_busy", int'(bus.busy), 1);
    run(1, 1'b0, bc);
    chk("hold_second_pass", int'(bus.pass), 0);

    // Async reset mid-run at vec=3.
    mode = 0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bus.vec == 3'd3) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("rst_reach_vec3", int'(hit), 1);
    #2 rst = 1'b1;
    #1 chk_all_zero("async_rst");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run(0, 1'b0, bc);
    chk("post_rst_busy_cycles", bc, 40);
    chk("post_rst_pass", int'(bus.pass), 1);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
